// File: rtl/dac_ch_scheduler_pkg.sv
// dac_ch_scheduler_pkg: scheduler state encoding, DAC command codes and frame width helper
package dac_ch_scheduler_pkg;
   typedef enum logic [2:0] {IDLE, START, WAIT, DONE, ERR, GAP} state_t;
   localparam logic [3:0] DAC_CMD_NOP   = 4'b0000;
   localparam logic [3:0] DAC_CMD_WRUPD = 4'b0011;
   function automatic int frame_w(input int cmd_w, input int addr_w, input int data_w);
      return cmd_w + addr_w + data_w;
   endfunction
endpackage

// File: rtl/dac_ch_scheduler_arb.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [IDX_W-1:0] idx,
   output logic             vld
);
   logic [IDX_W:0] k;
   always_comb begin
      idx = '0;
      vld = 1'b0;
      k   = '0;
      // scan from the far end so the request nearest ptr is written last and wins
      for (int i = N_CH - 1; i >= 0; i--) begin
         k = {1'b0, ptr} + (IDX_W + 1)'(i);
         k = (k >= (IDX_W + 1)'(N_CH)) ? k - (IDX_W + 1)'(N_CH) : k;
         if (req[k[IDX_W-1:0]]) begin
            idx = k[IDX_W-1:0];
            vld = 1'b1;
         end
      end
      gnt = vld ? (N_CH'(1) << idx) : '0;
   end
endmodule

// File: rtl/dac_ch_scheduler.sv
// dac_ch_scheduler: round-robin sharing of one SPI DAC write engine among N_CH setpoint requesters
module dac_ch_scheduler
   import dac_ch_scheduler_pkg::*;
#(
   parameter int               N_CH      = 4,
   parameter int               DATA_W    = 16,
   parameter int               ADDR_W    = 4,
   parameter int               CMD_W     = 4,
   parameter logic [CMD_W-1:0] CMD_WRUPD = CMD_W'(DAC_CMD_WRUPD),
   parameter int               TIMEOUT   = 4096,
   parameter int               GAP_CYC   = 4
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [N_CH-1:0]                           req_i,
   input  logic [N_CH*DATA_W-1:0]                    data_i,
   input  logic                                      err_clr_i,
   output logic [N_CH-1:0]                           ack_o,
   output logic                                      busy_o,
   output logic                                      err_o,
   output logic                                      spi_start_o,
   output logic [frame_w(CMD_W, ADDR_W, DATA_W)-1:0] spi_word_o,
   input  logic                                      spi_eow_i
);
   localparam int IDX_W = $clog2(N_CH);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W = $clog2(GAP_CYC + 2);
   localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
   state_t state, state_nx;
   logic [IDX_W-1:0] rr_ptr, gnt, arb_idx;
   logic [N_CH-1:0]  gnt_oh, arb_oh;
   logic             arb_vld;
   logic [TMO_W-1:0] tmo;
   logic [GAP_W-1:0] gap_cnt;
   rr_arbiter #(.N_CH(N_CH), .IDX_W(IDX_W)) u_arb (
      .req(req_i), .ptr(rr_ptr), .gnt(arb_oh), .idx(arb_idx), .vld(arb_vld)
   );
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) state <= IDLE;
      else state <= state_nx;
   // eow is checked before the timeout so a same-cycle tie completes the frame
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = arb_vld ? START : IDLE;
         START:     state_nx = WAIT;
         WAIT:      state_nx = spi_eow_i ? DONE : (tmo == '0) ? ERR : WAIT;
         DONE, ERR: state_nx = GAP;
         GAP:       state_nx = (gap_cnt == '0) ? IDLE : GAP;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         rr_ptr     <= '0;
         gnt        <= '0;
         gnt_oh     <= '0;
         spi_word_o <= '0;
         tmo        <= '0;
         gap_cnt    <= '0;
         err_o      <= 1'b0;
      end else begin
         if (state == IDLE && arb_vld) begin
            gnt        <= arb_idx;
            gnt_oh     <= arb_oh;
            spi_word_o <= {CMD_WRUPD, ADDR_W'(arb_idx), data_i[arb_idx*DATA_W +: DATA_W]};
         end
         if (state == START) tmo <= TMO_W'(TIMEOUT - 1);
         else if (state == WAIT && tmo != '0) tmo <= tmo - 1'b1;
         if (state == DONE || state == ERR) begin
            rr_ptr  <= (gnt == IDX_W'(N_CH - 1)) ? '0 : gnt + 1'b1;
            gap_cnt <= GAP_LD;
         end else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
         if (state == ERR) err_o <= 1'b1;
         else if (err_clr_i) err_o <= 1'b0;
      end
   assign spi_start_o = (state == START);
   assign busy_o      = (state != IDLE);
   assign ack_o       = (state == DONE) ? gnt_oh : '0;
endmodule

// File: tb/tb_dac_ch_scheduler.sv
// tb_dac_ch_scheduler: scoreboard bench for the DAC channel scheduler with a behavioural SPI writer
module tb_dac_ch_scheduler;
   localparam int TMO = 64;
   localparam int GAP = 4;
   logic        clk = 0;
   logic        rst_n = 0;
   logic [3:0]  req = '0;
   logic [15:0] dv [4];
   logic [63:0] data;
   logic        err_clr = 0;
   logic [3:0]  ack;
   logic        busy, err, spi_start, spi_eow;
   logic        eow_w = 0, spur = 0, prev_start = 0;
   logic [23:0] spi_word;
   int          n_chk = 0, n_err = 0, cyc = 0;
   int          wr_lat = 3, eow_cyc = 0, eow_n = 0, eow_used = 0, s = 0;
   bit          wr_en = 1, exact_gap = 0;
   logic [23:0] exp_word [$];
   logic [3:0]  exp_ack [$];

   assign data    = {dv[3], dv[2], dv[1], dv[0]};
   assign spi_eow = eow_w | spur;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dac_ch_scheduler #(.N_CH(4), .DATA_W(16), .ADDR_W(4), .CMD_W(4), .TIMEOUT(TMO), .GAP_CYC(GAP)) dut (
      .clk_i(clk), .rst_i(rst_n), .req_i(req), .data_i(data), .err_clr_i(err_clr),
      .ack_o(ack), .busy_o(busy), .err_o(err), .spi_start_o(spi_start),
      .spi_word_o(spi_word), .spi_eow_i(spi_eow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [23:0] frm(input int k);
      return {4'h3, 4'(k), dv[k]};
   endfunction

   task automatic push(input int k, input bit with_ack);
      exp_word.push_back(frm(k));
      if (with_ack) exp_ack.push_back(4'(1 << k));
   endtask

   task automatic serve(input int n, input bit hold);
      int got = 0;
      int t = 0;
      while (got < n && t < 2000) begin
         @(negedge clk);
         t++;
         if (ack != 0) begin
            got++;
            if (!hold) req = req & ~ack;
         end
      end
      chk("serve_count", got, n);
   endtask

   task automatic idle_wait(input int budget);
      int t = 0;
      while (busy && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("idle_wait", busy, 0);
   endtask

   task automatic wait_start(output int sc);
      int t = 0;
      bit seen = 0;
      sc = 0;
      while (!seen && t < 50) begin
         @(negedge clk);
         t++;
         if (spi_start) begin
            seen = 1;
            sc = cyc;
         end
      end
      chk("start_seen", seen, 1);
   endtask

   // behavioural SPI writer: eow wr_lat cycles after each start
   initial forever begin
      @(negedge clk);
      eow_w = 0;
      if (spi_start && wr_en) begin
         repeat (wr_lat) @(negedge clk);
         eow_w = 1;
         eow_cyc = cyc;
         eow_n++;
      end
   end

   always @(negedge clk) begin
      if (spi_start) begin
         if (exp_word.size() == 0) chk("unexp_start", spi_start, 0);
         else chk("word", spi_word, exp_word.pop_front());
         chk("start_1cyc", prev_start, 0);
         if (eow_n != eow_used) begin
            if (exact_gap) chk("gap_exact", cyc - eow_cyc, 3 + GAP);
            else chk("gap_min", 32'(cyc - eow_cyc >= 3 + GAP), 1);
            eow_used <= eow_n;
         end
      end
      if (ack != 0) begin
         if (exp_ack.size() == 0) chk("unexp_ack", ack, 0);
         else chk("ack", ack, exp_ack.pop_front());
         chk("ack_lat", cyc, eow_cyc + 1);
      end
      prev_start <= spi_start;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit, expected finish");
      $fatal(1);
   end

   initial begin
      dv[0] = 16'h0F0F; dv[1] = 16'h1234; dv[2] = 16'hABCD; dv[3] = 16'h5A5A;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_start", spi_start, 0);
      chk("rst_ack", ack, 0);
      chk("rst_err", err, 0);
      chk("rst_word", spi_word, 0);
      rst_n = 1;
      @(negedge clk);
      exp_word.push_back(24'h32ABCD);
      exp_ack.push_back(4'b0100);
      req = 4'b0100;
      @(negedge clk);
      chk("t1_start_lat", spi_start, 1);
      chk("t1_word", spi_word, 24'h32ABCD);
      serve(1, 0);
      idle_wait(20);
      push(3, 1); push(0, 1);
      req = 4'b1001;
      serve(2, 0);
      idle_wait(20);
      @(negedge clk); spur = 1;
      @(negedge clk); spur = 0;
      chk("t5_idle_busy", busy, 0);
      push(1, 1);
      req = 4'b0010;
      serve(1, 0);
      @(negedge clk); spur = 1;
      chk("t5_gap_busy", busy, 1);
      @(negedge clk); spur = 0;
      idle_wait(20);
      wr_lat = TMO;
      push(2, 1);
      req = 4'b0100;
      serve(1, 0);
      chk("t5_tie_err", err, 0);
      wr_lat = 3;
      idle_wait(20);
      wr_en = 0;
      push(3, 0);
      req = 4'b1000;
      wait_start(s);
      for (int i = 0; i < 200 && !err; i++) @(negedge clk);
      chk("t4_tmo_cyc", cyc - s, TMO + 2);
      req = 4'b0000;
      idle_wait(50);
      chk("t4_idle_cyc", cyc - s, TMO + 2 + GAP);
      chk("t4_err_sticky", err, 1);
      err_clr = 1;
      @(negedge clk); err_clr = 0;
      chk("t4_err_clr", err, 0);
      wr_en = 1;
      push(0, 1);
      req = 4'b0001;
      serve(1, 0);
      idle_wait(20);
      wr_en = 0;
      push(1, 0);
      req = 4'b0011;
      wait_start(s);
      repeat (3) @(negedge clk);
      #1 rst_n = 0;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_start", spi_start, 0);
      chk("t6_ack", ack, 0);
      chk("t6_word", spi_word, 0);
      @(negedge clk);
      rst_n = 1;
      wr_en = 1;
      push(0, 1); push(1, 1);
      serve(2, 0);
      idle_wait(20);
      @(negedge clk); rst_n = 0;
      @(negedge clk); rst_n = 1;
      push(0, 1); push(1, 1); push(2, 1); push(3, 1); push(0, 1);
      req = 4'b1111;
      serve(1, 1);
      exact_gap = 1;
      serve(4, 1);
      req = 4'b0000;
      exact_gap = 0;
      idle_wait(20);
      repeat (10) @(negedge clk);
      chk("sb_empty", exp_word.size() + exp_ack.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
